// File: rtl/AluCtrlSig_pkg.sv
// Shared ALU/branch control definitions: branch opcodes and the
// two-bit branch-history state encoding.
package AluCtrlSig_pkg;

    localparam logic [5:0] BEQ_op = 6'b000100;
    localparam logic [5:0] BNE_op = 6'b000101;

    typedef enum logic [1:0] {
        SNT = 2'd0,
        WNT = 2'd1,
        WT  = 2'd2,
        ST  = 2'd3
    } bp_state_t;

    function automatic logic is_branch_op(input logic [5:0] op);
        return (op == BEQ_op) || (op == BNE_op);
    endfunction

endpackage

// File: rtl/bht_counter.sv
// One branch-history entry: a two-bit saturating taken/not-taken counter.
//
// state | meaning
// SNT   | strongly not taken
// WNT   | weakly not taken (reset state)
// WT    | weakly taken
// ST    | strongly taken
module bht_counter
    import AluCtrlSig_pkg::*;
(
    input  logic      clk,
    input  logic      reset,
    input  logic      upd_en,
    input  logic      upd_taken,
    output bp_state_t state
);

    bp_state_t state_q, state_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= WNT;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (upd_en) begin
            unique case (state_q)
                SNT: state_d = upd_taken ? WNT : SNT;
                WNT: state_d = upd_taken ? WT  : SNT;
                WT:  state_d = upd_taken ? ST  : WNT;
                ST:  state_d = upd_taken ? ST  : WT;
                default: state_d = WNT;
            endcase
        end
    end

    assign state = state_q;

endmodule

// File: rtl/branch_pred_ctrl.sv
// Fetch-stage bimodal branch predictor with stage-2 resolution,
// flush/redirect generation and resolved/mispredicted statistics.
module branch_pred_ctrl
    import AluCtrlSig_pkg::*;
#(
    parameter int BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_s1,
    input  logic [31:0] inst_s1,
    input  logic        stall,
    input  logic        resolve_s2,
    input  logic        taken_s2,
    input  logic [31:0] target_s2,
    input  logic [31:0] pc4_s2,
    output logic        pred_taken_s1,
    output logic [31:0] pred_target_s1,
    output logic        flush,
    output logic [31:0] redirect_pc,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispred_cnt
);

    localparam int IW = $clog2(BHT_ENTRIES);

    bp_state_t        entry_state [BHT_ENTRIES];
    logic [IW-1:0]    rd_idx;
    logic             is_branch;
    logic             pred_taken;
    logic [31:0]      imm_off;
    logic             counted;
    logic             flush_int;

    logic             rec_valid_q, rec_valid_d;
    logic             rec_pred_q,  rec_pred_d;
    logic [IW-1:0]    rec_idx_q,   rec_idx_d;
    logic [31:0]      branch_cnt_q,  branch_cnt_d;
    logic [31:0]      mispred_cnt_q, mispred_cnt_d;

    logic             unused_inst_bits;
    assign unused_inst_bits = ^inst_s1[25:16];

    assign rd_idx    = pc_s1[IW+1:2];
    assign is_branch = is_branch_op(inst_s1[31:26]);
    assign imm_off   = {{14{inst_s1[15]}}, inst_s1[15:0], 2'b00};

    // The table read is the registered entry state, so a same-cycle update
    // to this index is not visible until the next cycle.
    assign pred_taken = is_branch &&
                        ((entry_state[rd_idx] == WT) || (entry_state[rd_idx] == ST));

    assign counted   = resolve_s2 && rec_valid_q && !stall;
    assign flush_int = counted && (taken_s2 != rec_pred_q);

    for (genvar i = 0; i < BHT_ENTRIES; i++) begin : g_bht
        bht_counter u_bht_counter (
            .clk       (clk),
            .reset     (reset),
            .upd_en    (counted && (rec_idx_q == IW'(i))),
            .upd_taken (taken_s2),
            .state     (entry_state[i])
        );
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rec_valid_q   <= 1'b0;
            rec_pred_q    <= 1'b0;
            rec_idx_q     <= '0;
            branch_cnt_q  <= '0;
            mispred_cnt_q <= '0;
        end else begin
            rec_valid_q   <= rec_valid_d;
            rec_pred_q    <= rec_pred_d;
            rec_idx_q     <= rec_idx_d;
            branch_cnt_q  <= branch_cnt_d;
            mispred_cnt_q <= mispred_cnt_d;
        end
    end

    always_comb begin
        rec_valid_d   = rec_valid_q;
        rec_pred_d    = rec_pred_q;
        rec_idx_d     = rec_idx_q;
        branch_cnt_d  = branch_cnt_q;
        mispred_cnt_d = mispred_cnt_q;
        if (!stall) begin
            // A flush kills the fetch-stage instruction, so it never resolves.
            rec_valid_d = is_branch && !flush_int;
            rec_pred_d  = pred_taken;
            rec_idx_d   = rd_idx;
            if (counted)   branch_cnt_d  = branch_cnt_q + 32'd1;
            if (flush_int) mispred_cnt_d = mispred_cnt_q + 32'd1;
        end
    end

    assign pred_taken_s1  = pred_taken && !reset;
    assign pred_target_s1 = pc_s1 + 32'd4 + imm_off;
    assign flush          = flush_int && !reset;
    assign redirect_pc    = flush ? (taken_s2 ? target_s2 : pc4_s2) : 32'd0;
    assign branch_cnt     = branch_cnt_q;
    assign mispred_cnt    = mispred_cnt_q;

endmodule
